// File: rtl/tape_pulse_gen.sv
// ============================================================================
// Module      : tape_pulse_gen
// Description : Cassette tape block player. It emits a pilot tone, two sync
//               pulses and then a serial byte stream as half-period pulses on
//               tape_level. All timing is measured in ce_tick units (one tick
//               per tape T-state).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock (motherboard domain)
//   reset_n      in   asynchronous active-low reset
//   ce_tick      in   one-clk timing enable, one per tape T-state
//   start        in   one-clk pulse; begins a block when idle
//   pilot_len    in   [15:0] pilot pulse length (ticks)
//   pilot_cnt    in   [15:0] number of pilot pulses (0 = no pilot)
//   sync1_len    in   [15:0] first sync pulse length
//   sync2_len    in   [15:0] second sync pulse length
//   zero_len     in   [15:0] pulse length for a 0 bit (two pulses per bit)
//   one_len      in   [15:0] pulse length for a 1 bit (two pulses per bit)
//   data         in   [7:0]  byte to play, MSB first
//   data_valid   in   byte available
//   data_last    in   byte is the final one of the block
//   data_ready   out  block can accept a byte this clk
//   motor        in   tape motor control
//   tape_level   out  pulse level towards the motherboard tape input
//   busy         out  block active (any state but IDLE)
//   done         out  one-clk completion pulse
//   underflow    out  sticky: a byte was needed but none was offered
// ----------------------------------------------------------------------------
// Configuration macro
//   TAPE_MOTOR_GATE_EN : when defined, motor=0 suspends all pulse timing
//                        (ce_tick ignored, counters and level frozen). When
//                        undefined the motor input is unused.
// ============================================================================
`default_nettype none

module tape_pulse_gen (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_tick,
  input  logic        start,
  input  logic [15:0] pilot_len,
  input  logic [15:0] pilot_cnt,
  input  logic [15:0] sync1_len,
  input  logic [15:0] sync2_len,
  input  logic [15:0] zero_len,
  input  logic [15:0] one_len,
  input  logic [7:0]  data,
  input  logic        data_valid,
  input  logic        data_last,
  output logic        data_ready,
  input  logic        motor,
  output logic        tape_level,
  output logic        busy,
  output logic        done,
  output logic        underflow
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PILOT = 3'd1,
    S_SYNC1 = 3'd2,
    S_SYNC2 = 3'd3,
    S_DATA  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Parameters captured on the accepted start
  logic [15:0] r_pilot_len;
  logic [15:0] r_sync1_len;
  logic [15:0] r_sync2_len;
  logic [15:0] r_zero_len;
  logic [15:0] r_one_len;

  logic [15:0] r_pulses;    // pilot pulses still to emit
  logic [15:0] r_cnt;       // ticks elapsed in the current pulse
  logic [7:0]  r_byte;      // byte being played
  logic        r_have;      // r_byte holds a byte still being played
  logic        r_last;      // r_byte is the final byte of the block
  logic [2:0]  r_bit_idx;   // bit of r_byte being played
  logic        r_half;      // 0: first pulse of the bit, 1: second pulse
  logic        r_level;
  logic        r_underflow;

  logic        w_tick;
  logic [15:0] w_len;
  logic [15:0] w_len_eff;
  logic [16:0] w_cnt_inc;
  logic        w_timing;
  logic        w_pulse_end;
  logic        w_xfer;

`ifdef TAPE_MOTOR_GATE_EN
  // A stopped motor simply swallows ticks, so every counter resumes exactly
  // where it was frozen.
  assign w_tick = ce_tick & motor;
`else
  logic w_motor_unused;
  assign w_motor_unused = motor;
  assign w_tick         = ce_tick;
`endif

  // Length of the pulse currently being generated
  always_comb begin
    w_len = 16'd0;
    case (r_state)
      S_PILOT: w_len = r_pilot_len;
      S_SYNC1: w_len = r_sync1_len;
      S_SYNC2: w_len = r_sync2_len;
      S_DATA:  w_len = r_byte[r_bit_idx] ? r_one_len : r_zero_len;
      default: w_len = 16'd0;
    endcase
  end

  // A zero length would otherwise never terminate; play it as one tick.
  assign w_len_eff = (w_len == 16'd0) ? 16'd1 : w_len;
  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

  // In DATA the timing only runs while a byte is held; without one the
  // pulse machinery is frozen (starvation or waiting for the handshake).
  assign w_timing    = (r_state == S_PILOT) || (r_state == S_SYNC1) ||
                       (r_state == S_SYNC2) || ((r_state == S_DATA) && r_have);
  assign w_pulse_end = w_timing && w_tick && (w_cnt_inc >= {1'b0, w_len_eff});
  assign w_xfer      = data_valid && data_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and status outputs
  always_comb begin
    w_next     = r_state;
    busy       = 1'b1;
    done       = 1'b0;
    data_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = (pilot_cnt == 16'd0) ? S_SYNC1 : S_PILOT;
        end
      end
      S_PILOT: begin
        if (w_pulse_end && (r_pulses == 16'd1)) begin
          w_next = S_SYNC1;
        end
      end
      S_SYNC1: begin
        if (w_pulse_end) begin
          w_next = S_SYNC2;
        end
      end
      S_SYNC2: begin
        if (w_pulse_end) begin
          w_next = S_DATA;
        end
      end
      S_DATA: begin
        data_ready = !r_have;
        if (w_pulse_end && r_half && (r_bit_idx == 3'd0) && r_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Pulse timing, byte holding and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pilot_len <= 16'd0;
      r_sync1_len <= 16'd0;
      r_sync2_len <= 16'd0;
      r_zero_len  <= 16'd0;
      r_one_len   <= 16'd0;
      r_pulses    <= 16'd0;
      r_cnt       <= 16'd0;
      r_byte      <= 8'd0;
      r_have      <= 1'b0;
      r_last      <= 1'b0;
      r_bit_idx   <= 3'd0;
      r_half      <= 1'b0;
      r_level     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_pilot_len <= pilot_len;
        r_sync1_len <= sync1_len;
        r_sync2_len <= sync2_len;
        r_zero_len  <= zero_len;
        r_one_len   <= one_len;
        r_pulses    <= pilot_cnt;
        r_cnt       <= 16'd0;
        r_have      <= 1'b0;
        r_half      <= 1'b0;
        r_underflow <= 1'b0;
      end

      if (w_pulse_end) begin
        r_level <= ~r_level;
        r_cnt   <= 16'd0;
        if (r_state == S_PILOT) begin
          r_pulses <= r_pulses - 16'd1;
        end
        if (r_state == S_DATA) begin
          r_half <= ~r_half;
          if (r_half) begin
            if (r_bit_idx == 3'd0) begin
              r_have <= 1'b0;
            end else begin
              r_bit_idx <= r_bit_idx - 3'd1;
            end
          end
        end
      end else if (w_timing && w_tick) begin
        r_cnt <= w_cnt_inc[15:0];
      end

      // Only possible while no byte is held, so it never collides with a
      // pulse end; a tick in this clk is not counted for the new byte.
      if (w_xfer) begin
        r_byte    <= data;
        r_last    <= data_last;
        r_have    <= 1'b1;
        r_bit_idx <= 3'd7;
        r_half    <= 1'b0;
        r_cnt     <= 16'd0;
      end

      if ((r_state == S_DATA) && !r_have && !data_valid) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign tape_level = r_level;
  assign underflow  = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_tape_pulse_gen.sv
// ============================================================================
// Module      : tb_tape_pulse_gen
// Description : Directed self-checking bench for tape_pulse_gen. Each block
//               is played with a simple runner that records the tick numbers
//               at which tape_level toggles; the scenario tasks compare them
//               against hand-computed tick lists.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tape_pulse_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_tick = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pilot_len = 16'd0;
  logic [15:0] pilot_cnt = 16'd0;
  logic [15:0] sync1_len = 16'd0;
  logic [15:0] sync2_len = 16'd0;
  logic [15:0] zero_len = 16'd0;
  logic [15:0] one_len = 16'd0;
  logic [7:0]  data = 8'd0;
  logic        data_valid = 1'b0;
  logic        data_last = 1'b0;
  logic        data_ready;
  logic        motor = 1'b1;
  logic        tape_level;
  logic        busy;
  logic        done;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  // Runner results
  int   tick_n;
  int   tg [64];
  int   tg_n;
  int   done_tick;
  int   done_clks;
  int   xfers;
  logic busy_after;
  logic level_after;
  logic uf_hold;
  logic rdy_hold;
  logic uf_start;
  logic uf_end;

  tape_pulse_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce_tick    (ce_tick),
    .start      (start),
    .pilot_len  (pilot_len),
    .pilot_cnt  (pilot_cnt),
    .sync1_len  (sync1_len),
    .sync2_len  (sync2_len),
    .zero_len   (zero_len),
    .one_len    (one_len),
    .data       (data),
    .data_valid (data_valid),
    .data_last  (data_last),
    .data_ready (data_ready),
    .motor      (motor),
    .tape_level (tape_level),
    .busy       (busy),
    .done       (done),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock; outputs are settled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (ce_tick) tick_n++;
  endtask

  // Plays one block with ce_tick every clk and records toggle ticks.
  //   hold       : data_valid is withheld until this many ticks have passed
  //   restart_at : tick count at which a (to be ignored) start is pulsed
  //   moff_*     : motor is low for moff_len ticks after tick moff_from
  task automatic run_block(input int hold, input int restart_at,
                           input int moff_from, input int moff_len);
    logic prev;
    logic sent;
    logic xfer_now;
    for (int i = 0; i < 64; i++) tg[i] = -1;
    tg_n = 0; done_tick = -1; done_clks = 0; xfers = 0; sent = 1'b0;
    busy_after = 1'b1; level_after = 1'bx; uf_hold = 1'bx; rdy_hold = 1'bx;
    ce_tick = 1'b1;
    start   = 1'b1;
    step();
    start    = 1'b0;
    tick_n   = 0;
    uf_start = underflow;
    prev     = tape_level;
    for (int i = 0; i < 400; i++) begin
      if (hold > 0 && tick_n == hold && !sent) begin
        uf_hold  = underflow;
        rdy_hold = data_ready;
      end
      if (!sent && tick_n >= hold) data_valid = 1'b1;
      motor = !((tick_n >= moff_from) && (tick_n < moff_from + moff_len));
      start = (tick_n == restart_at);
      xfer_now = data_ready && data_valid;
      step();
      if (xfer_now) begin
        xfers++;
        data_valid = 1'b0;
        sent = 1'b1;
      end
      if (tape_level !== prev) begin
        if (tg_n < 64) tg[tg_n] = tick_n;
        tg_n++;
        prev = tape_level;
      end
      if (done === 1'b1) begin
        done_clks++;
        if (done_tick < 0) done_tick = tick_n;
      end
      if (done_tick >= 0 && done !== 1'b1) begin
        busy_after  = busy;
        level_after = tape_level;
        break;
      end
    end
    uf_end     = underflow;
    start      = 1'b0;
    motor      = 1'b1;
    data_valid = 1'b0;
    ce_tick    = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tape_level !== 1'b0) begin errors++; $display("FAIL reset tape_level got %b expected 0", tape_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b expected 0", done); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset data_ready got %b expected 0", data_ready); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset underflow got %b expected 0", underflow); end
    reset_n = 1'b1;
  endtask

  // Pilot 3x4, sync 2/3, byte 0xA5 (zero 2, one 4); a start during PILOT
  // must not disturb anything. Transfer consumes tick 18.
  task automatic test_pilot_sync_data();
    int exp_t [21] = '{4, 8, 12, 14, 17, 22, 26, 28, 30, 34, 38, 40, 42,
                       44, 46, 50, 54, 56, 58, 62, 66};
    pilot_cnt = 16'd3; pilot_len = 16'd4; sync1_len = 16'd2; sync2_len = 16'd3;
    zero_len = 16'd2; one_len = 16'd4; data = 8'hA5; data_last = 1'b1;
    run_block(0, 5, -1, 0);
    checks++; if (tg_n !== 21) begin errors++; $display("FAIL a5_toggle_count got %0d expected 21", tg_n); end
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (tg[i] !== exp_t[i]) begin errors++; $display("FAIL a5_toggle[%0d] got tick %0d expected tick %0d", i, tg[i], exp_t[i]); end
    end
    checks++; if (done_tick !== 66) begin errors++; $display("FAIL a5_done_tick got %0d expected 66", done_tick); end
    checks++; if (done_clks !== 1) begin errors++; $display("FAIL a5_done_width got %0d expected 1", done_clks); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL a5_busy_after got %b expected 0", busy_after); end
    checks++; if (level_after !== 1'b1) begin errors++; $display("FAIL a5_level_hold got %b expected 1", level_after); end
    checks++; if (xfers !== 1) begin errors++; $display("FAIL a5_transfers got %0d expected 1", xfers); end
    checks++; if (uf_end !== 1'b0) begin errors++; $display("FAIL a5_underflow got %b expected 0", uf_end); end
  endtask

  // No pilot, sync 1/1, data withheld for ticks 3..12, byte 0xFF (one 2).
  task automatic test_underflow();
    pilot_cnt = 16'd0; pilot_len = 16'd9; sync1_len = 16'd1; sync2_len = 16'd1;
    zero_len = 16'd2; one_len = 16'd2; data = 8'hFF; data_last = 1'b1;
    run_block(12, -1, -1, 0);
    checks++; if (tg_n !== 18) begin errors++; $display("FAIL uf_toggle_count got %0d expected 18", tg_n); end
    for (int i = 0; i < 18; i++) begin
      int e;
      e = (i < 2) ? (i + 1) : (15 + 2 * (i - 2));
      checks++;
      if (tg[i] !== e) begin errors++; $display("FAIL uf_toggle[%0d] got tick %0d expected tick %0d", i, tg[i], e); end
    end
    checks++; if (uf_hold !== 1'b1) begin errors++; $display("FAIL uf_flag_while_starved got %b expected 1", uf_hold); end
    checks++; if (rdy_hold !== 1'b1) begin errors++; $display("FAIL uf_ready_while_starved got %b expected 1", rdy_hold); end
    checks++; if (uf_end !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b expected 1", uf_end); end
    checks++; if (done_tick !== 45) begin errors++; $display("FAIL uf_done_tick got %0d expected 45", done_tick); end
  endtask

  // Every length zero: each pulse lasts exactly one tick. Start clears the
  // underflow left by the previous block; a start in SYNC1 is ignored.
  task automatic test_zero_len();
    pilot_cnt = 16'd2; pilot_len = 16'd0; sync1_len = 16'd0; sync2_len = 16'd0;
    zero_len = 16'd0; one_len = 16'd0; data = 8'h3C; data_last = 1'b1;
    run_block(0, 2, -1, 0);
    checks++; if (uf_start !== 1'b0) begin errors++; $display("FAIL zl_underflow_clear got %b expected 0", uf_start); end
    checks++; if (tg_n !== 20) begin errors++; $display("FAIL zl_toggle_count got %0d expected 20", tg_n); end
    for (int i = 0; i < 20; i++) begin
      int e;
      e = (i < 4) ? (i + 1) : (i + 2);
      checks++;
      if (tg[i] !== e) begin errors++; $display("FAIL zl_toggle[%0d] got tick %0d expected tick %0d", i, tg[i], e); end
    end
    checks++; if (done_tick !== 21) begin errors++; $display("FAIL zl_done_tick got %0d expected 21", done_tick); end
  endtask

  // One 4-tick pilot pulse with motor low for ticks 3..7.
  task automatic test_motor();
    int first;
    pilot_cnt = 16'd1; pilot_len = 16'd4; sync1_len = 16'd1; sync2_len = 16'd1;
    zero_len = 16'd1; one_len = 16'd1; data = 8'h00; data_last = 1'b1;
    run_block(0, -1, 2, 5);
`ifdef TAPE_MOTOR_GATE_EN
    first = 9;
`else
    first = 4;
`endif
    checks++; if (tg_n !== 19) begin errors++; $display("FAIL motor_toggle_count got %0d expected 19", tg_n); end
    for (int i = 0; i < 19; i++) begin
      int e;
      e = (i < 3) ? (first + i) : (first + i + 1);
      checks++;
      if (tg[i] !== e) begin errors++; $display("FAIL motor_toggle[%0d] got tick %0d expected tick %0d", i, tg[i], e); end
    end
  endtask

  // Sparse ce_tick timing, then asynchronous reset in the middle of PILOT,
  // then a start on the very first clk after reset release.
  task automatic test_async_reset();
    logic lv0;
    pilot_cnt = 16'd50; pilot_len = 16'd3;
    ce_tick = 1'b0;
    start   = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_start_busy got %b expected 1", busy); end
    lv0 = tape_level;
    for (int k = 1; k <= 5; k++) begin
      ce_tick = k[0];
      step();
      if (k == 4) begin
        checks++; if (tape_level !== lv0) begin errors++; $display("FAIL ar_two_ticks_level got %b expected %b", tape_level, lv0); end
      end
    end
    checks++; if (tape_level !== ~lv0) begin errors++; $display("FAIL ar_third_tick_level got %b expected %b", tape_level, ~lv0); end
    for (int k = 0; k < 20 && tape_level !== 1'b1; k++) begin
      ce_tick = k[0];
      step();
    end
    checks++; if (tape_level !== 1'b1) begin errors++; $display("FAIL ar_level_high_before_reset got %b expected 1", tape_level); end
    ce_tick = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (tape_level !== 1'b0) begin errors++; $display("FAIL ar_tape_level got %b expected 0", tape_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b expected 0", busy); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL ar_data_ready got %b expected 0", data_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ar_done got %b expected 0", done); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    pilot_cnt = 16'd1; pilot_len = 16'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_first_clk_start got %b expected 1", busy); end
  endtask

  initial begin
    test_reset();
    test_pilot_sync_data();
    test_underflow();
    test_zero_len();
    test_motor();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
